// File: rtl/pe_core.sv
// Complex-arithmetic processing element: batches eight complex operands, runs a
// fixed program (three complex multiplies, one complex add), forwards two neighbour chains.
module pe_core #(
  parameter int DATA_WIDTH = 16,
  parameter int RF_DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_pe_v,
  input  logic [2*DATA_WIDTH-1:0]   din_pe,
  input  logic                      din_shift_v,
  input  logic [2*DATA_WIDTH-1:0]   din_shift,
  input  logic                      din_tx_v,
  input  logic [2*DATA_WIDTH-1:0]   din_tx,
  output logic                      dout_pe_v,
  output logic [2*DATA_WIDTH-1:0]   dout_pe,
  output logic                      dout_tx_v,
  output logic [2*DATA_WIDTH-1:0]   dout_tx,
  output logic                      dout_shift_v,
  output logic [2*DATA_WIDTH-1:0]   dout_shift
);

  localparam int W     = DATA_WIDTH;
  localparam int CW    = 2 * DATA_WIDTH;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int SW    = 2 * DATA_WIDTH + 1;
  localparam int PTR_W = $clog2(RF_DEPTH);

  typedef enum logic {
    ST_LOAD,
    ST_COMPUTE
  } state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [1:0]       op_q, op_d;
  logic             rf_we;
  logic             issue;

  logic [CW-1:0]    rf_q [RF_DEPTH];

  logic             s1_v_q;
  logic [CW-1:0]    s1_q;
  logic             dout_pe_v_q;
  logic [CW-1:0]    dout_pe_q;
  logic             dout_shift_v_q, dout_tx_v_q;
  logic [CW-1:0]    dout_shift_q, dout_tx_q;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    op_d    = op_q;
    rf_we   = 1'b0;
    issue   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (din_pe_v) begin
          rf_we  = 1'b1;
          wptr_d = wptr_q + PTR_W'(1);
          if (wptr_q == PTR_W'(RF_DEPTH - 1)) begin
            state_d = ST_COMPUTE;
            op_d    = 2'd0;
          end
        end
      end
      ST_COMPUTE: begin
        issue = 1'b1;
        op_d  = op_q + 2'd1;
        if (op_q == 2'd3) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      wptr_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      op_q    <= op_d;
    end
  end

  // NOTE: the register file is small and must read back zero after reset, so it is cleared explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[wptr_q] <= din_pe;
    end
  end

  // Operands for op k are the register pair R(2k), R(2k+1).
  logic [CW-1:0]        opa, opb;
  logic signed [W-1:0]  a_re, a_im, b_re, b_im;
  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [SW-1:0] sum_re, sum_im;
  logic signed [W-1:0]  add_re, add_im;
  logic [CW-1:0]        result;
  logic                 unused_sum_bits;

  assign opa    = rf_q[{op_q, 1'b0}];
  assign opb    = rf_q[{op_q, 1'b1}];
  assign a_re   = opa[CW-1:W];
  assign a_im   = opa[W-1:0];
  assign b_re   = opb[CW-1:W];
  assign b_im   = opb[W-1:0];

  assign p_rr   = PW'(a_re) * PW'(b_re);
  assign p_ii   = PW'(a_im) * PW'(b_im);
  assign p_ri   = PW'(a_re) * PW'(b_im);
  assign p_ir   = PW'(a_im) * PW'(b_re);
  assign sum_re = SW'(p_rr) - SW'(p_ii);
  assign sum_im = SW'(p_ri) + SW'(p_ir);
  assign add_re = a_re + b_re;
  assign add_im = a_im + b_im;

  assign result = (op_q == 2'd3) ? {add_re, add_im}
                                 : {sum_re[W-1:0], sum_im[W-1:0]};
  // Results wrap to W bits; the upper sum bits are intentionally discarded.
  assign unused_sum_bits = ^{sum_re[SW-1:W], sum_im[SW-1:W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q      <= 1'b0;
      s1_q        <= '0;
      dout_pe_v_q <= 1'b0;
      dout_pe_q   <= '0;
    end else begin
      s1_v_q      <= issue;
      if (issue) s1_q <= result;
      dout_pe_v_q <= s1_v_q;
      if (s1_v_q) dout_pe_q <= s1_q;
    end
  end

  // Neighbour chains: valid always follows, data holds when the input is not valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_shift_v_q <= 1'b0;
      dout_shift_q   <= '0;
      dout_tx_v_q    <= 1'b0;
      dout_tx_q      <= '0;
    end else begin
      dout_shift_v_q <= din_shift_v;
      if (din_shift_v) dout_shift_q <= din_shift;
      dout_tx_v_q    <= din_tx_v;
      if (din_tx_v) dout_tx_q <= din_tx;
    end
  end

  assign dout_pe_v    = dout_pe_v_q;
  assign dout_pe      = dout_pe_q;
  assign dout_shift_v = dout_shift_v_q;
  assign dout_shift   = dout_shift_q;
  assign dout_tx_v    = dout_tx_v_q;
  assign dout_tx      = dout_tx_q;

endmodule

// File: tb/tb_pe_core.sv
// Self-checking bench for pe_core: scoreboard of expected results with arrival cycle,
// plus inline checks of reset, chains, overrun and mid-compute reset.
module tb_pe_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_pe_v, din_shift_v, din_tx_v;
  logic [31:0] din_pe, din_shift, din_tx;
  logic        dout_pe_v, dout_tx_v, dout_shift_v;
  logic [31:0] dout_pe, dout_tx, dout_shift;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t        sb[$];
  logic [31:0] last_pe = '0;

  pe_core #(.DATA_WIDTH(16), .RF_DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .din_pe_v     (din_pe_v),
    .din_pe       (din_pe),
    .din_shift_v  (din_shift_v),
    .din_shift    (din_shift),
    .din_tx_v     (din_tx_v),
    .din_tx       (din_tx),
    .dout_pe_v    (dout_pe_v),
    .dout_pe      (dout_pe),
    .dout_tx_v    (dout_tx_v),
    .dout_tx      (dout_tx),
    .dout_shift_v (dout_shift_v),
    .dout_shift   (dout_shift)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result monitor: every valid result must match the scoreboard head at its cycle;
  // otherwise dout_pe must hold the last delivered value.
  always @(negedge clk) begin
    if (rst) begin
      last_pe = '0;
    end else if (dout_pe_v) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got %h at cycle %0d, none expected", dout_pe, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (dout_pe !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL result: got %h at cycle %0d, expected %h at cycle %0d",
                   dout_pe, cyc, e.data, e.cyc);
        end
        last_pe = e.data;
      end
    end else begin
      tests++;
      if (dout_pe !== last_pe) begin
        fails++;
        $display("FAIL hold: dout_pe %h, expected %h", dout_pe, last_pe);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input bit is_add);
    longint ar, ai, br, bi, re, im;
    ar = longint'($signed(x[31:16]));
    ai = longint'($signed(x[15:0]));
    br = longint'($signed(y[31:16]));
    bi = longint'($signed(y[15:0]));
    if (is_add) begin
      re = ar + br;
      im = ai + bi;
    end else begin
      re = ar * br - ai * bi;
      im = ar * bi + ai * br;
    end
    return {re[15:0], im[15:0]};
  endfunction

  task automatic model_batch(input logic [31:0] w[8], output logic [31:0] e[4]);
    for (int k = 0; k < 4; k++) e[k] = model(w[2*k], w[2*k+1], k == 3);
  endtask

  // Drives eight valid words (optionally with bubbles); leaves din_pe_v high after the 8th.
  task automatic send_batch(input logic [31:0] w[8], input logic [31:0] e[4],
                            input bit gaps, input bit push);
    for (int i = 0; i < 8; i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 2);
        repeat (n) begin
          tick();
          din_pe_v = 1'b0;
          din_pe   = $urandom;
        end
      end
      tick();
      din_pe_v = 1'b1;
      din_pe   = w[i];
    end
    if (push) for (int i = 0; i < 4; i++) sb.push_back('{data: e[i], cyc: cyc + 3 + i});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      din_pe_v = 1'b0;
      din_pe   = $urandom;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      din_pe_v    = 1'($urandom);
      din_pe      = $urandom;
      din_shift_v = 1'($urandom);
      din_shift   = $urandom;
      din_tx_v    = 1'($urandom);
      din_tx      = $urandom;
      tests++;
      if ({dout_pe_v, dout_shift_v, dout_tx_v} !== 3'b000 ||
          dout_pe !== '0 || dout_shift !== '0 || dout_tx !== '0) begin
        fails++;
        $display("FAIL reset_outputs: v=%b pe=%h sh=%h tx=%h, expected all 0",
                 {dout_pe_v, dout_shift_v, dout_tx_v}, dout_pe, dout_shift, dout_tx);
      end
    end
    tick();
    rst         = 1'b0;
    din_pe_v    = 1'b0;
    din_shift_v = 1'b0;
    din_tx_v    = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] w[8];
    logic [31:0] e[4];
    w = '{32'h0004_0002, 32'h0003_0001, 32'h0008_0006, 32'h0007_0005,
          32'h000C_000A, 32'h000B_0009, 32'h0004_0002, 32'h0003_0001};
    e = '{32'h000A_000A, 32'h001A_0052, 32'h002A_00DA, 32'h0007_0003};
    send_batch(w, e, 1'b0, 1'b1);
    idle(1);
    wait_drain();
  endtask

  task automatic test_gapped_overrun();
    logic [31:0] w[8];
    logic [31:0] e[4];
    logic [31:0] w2[8];
    logic [31:0] e2[4];
    w = '{32'h0004_0002, 32'h0003_0001, 32'h0008_0006, 32'h0007_0005,
          32'h000C_000A, 32'h000B_0009, 32'h0004_0002, 32'h0003_0001};
    e = '{32'h000A_000A, 32'h001A_0052, 32'h002A_00DA, 32'h0007_0003};
    send_batch(w, e, 1'b1, 1'b1);
    // Valid words during compute must be dropped.
    repeat (4) begin
      tick();
      din_pe_v = 1'b1;
      din_pe   = $urandom;
    end
    for (int i = 0; i < 8; i++) w2[i] = $urandom;
    model_batch(w2, e2);
    send_batch(w2, e2, 1'b0, 1'b1);
    idle(1);
    wait_drain();
  endtask

  task automatic test_wrap_sign();
    logic [31:0] w[8];
    logic [31:0] e[4];
    w = '{32'h7FFF_7FFF, 32'h7FFF_7FFF, 32'h8000_8000, 32'h8000_8000,
          32'h8000_7FFF, 32'h7FFF_8000, 32'hFFFF_8000, 32'h0001_8000};
    model_batch(w, e);
    e[0] = 32'h0000_0002;
    e[3] = 32'h0000_0000;
    send_batch(w, e, 1'b0, 1'b1);
    idle(1);
    wait_drain();
  endtask

  task automatic test_chains();
    logic [31:0] w[8];
    logic [31:0] e[4];
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    model_batch(w, e);
    fork
      begin
        send_batch(w, e, 1'b0, 1'b1);
        idle(1);
      end
      begin
        tick();
        din_shift_v = 1'b1; din_shift = 32'h0000_0005;
        din_tx_v    = 1'b1; din_tx    = 32'h0000_0006;
        tick();
        tests++;
        if (dout_shift_v !== 1'b1 || dout_shift !== 32'h0000_0005) begin
          fails++;
          $display("FAIL shift_load: v=%b d=%h, expected 1 00000005", dout_shift_v, dout_shift);
        end
        tests++;
        if (dout_tx_v !== 1'b1 || dout_tx !== 32'h0000_0006) begin
          fails++;
          $display("FAIL tx_load: v=%b d=%h, expected 1 00000006", dout_tx_v, dout_tx);
        end
        din_shift_v = 1'b0; din_shift = 32'h0000_0009;
        din_tx_v    = 1'b0; din_tx    = 32'h0000_000A;
        repeat (2) begin
          tick();
          tests++;
          if (dout_shift_v !== 1'b0 || dout_shift !== 32'h0000_0005) begin
            fails++;
            $display("FAIL shift_hold: v=%b d=%h, expected 0 00000005", dout_shift_v, dout_shift);
          end
          tests++;
          if (dout_tx_v !== 1'b0 || dout_tx !== 32'h0000_0006) begin
            fails++;
            $display("FAIL tx_hold: v=%b d=%h, expected 0 00000006", dout_tx_v, dout_tx);
          end
        end
      end
    join
    wait_drain();
  endtask

  task automatic test_mid_reset();
    logic [31:0] w[8];
    logic [31:0] e[4];
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    model_batch(w, e);
    send_batch(w, e, 1'b0, 1'b0);
    idle(1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(8);
    // Partial load interrupted by reset must restart at R0.
    for (int i = 0; i < 3; i++) begin
      tick();
      din_pe_v = 1'b1;
      din_pe   = $urandom;
    end
    tick();
    din_pe_v = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) w[i] = $urandom;
    model_batch(w, e);
    send_batch(w, e, 1'b1, 1'b1);
    idle(1);
    wait_drain();
  endtask

  initial begin
    rst         = 1'b1;
    din_pe_v    = 1'b0;
    din_pe      = '0;
    din_shift_v = 1'b0;
    din_shift   = '0;
    din_tx_v    = 1'b0;
    din_tx      = '0;
    test_reset();
    test_basic();
    test_gapped_overrun();
    test_wrap_sign();
    test_chains();
    test_mid_reset();
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
